// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants and types used by the write-port scheduler.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

    typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_wr_sched_rr_arb2.sv
// Two-way round-robin arbiter; the most recently granted requester loses a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       clr,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_grant_reg;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset value of 1 makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (clr) begin
            last_grant_reg <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_grant_reg <= grant[1];
        end
    end
endmodule

// File: rtl/regfile_wr_sched.sv
// Register-file write-port scheduler: zero-fills all registers after reset, then
// round-robins two write-back requesters onto one registered write port.
module regfile_wr_sched
    import rv32i_pkg::*;
#(
    parameter int XLEN = rv32i_pkg::XLEN,
    parameter int AW   = rv32i_pkg::AW,
    parameter int NREG = rv32i_pkg::NREG
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_d,
    output logic            init_busy
);
    sched_state_t    state_reg, state_next;
    logic [AW-1:0]   cnt_reg, cnt_next;
    logic            rf_we_reg, rf_we_next;
    logic [AW-1:0]   rf_addr_reg, rf_addr_next;
    logic [XLEN-1:0] rf_d_reg, rf_d_next;

    logic            run;
    logic [1:0]      req_vec;
    logic [1:0]      grant;
    logic [1:0]      ready_vec;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    assign run     = (state_reg == ST_RUN);
    // Requests are masked during INIT so the arbiter state is frozen there.
    assign req_vec = {req1_valid, req0_valid} & {2{run}};

    rr_arb2 u_arb (
        .clk    (clk),
        .clr    (clr),
        .req    (req_vec),
        .accept (accept),
        .grant  (grant)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = run && grant[gi];
        end
    endgenerate

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign accept     = |(ready_vec & req_vec);
    assign sel_addr   = grant[1] ? req1_addr : req0_addr;
    assign sel_data   = grant[1] ? req1_data : req0_data;
    assign init_busy  = (state_reg == ST_INIT);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rf_we_next   = 1'b0;
        rf_addr_next = rf_addr_reg;
        rf_d_next    = rf_d_reg;
        case (state_reg)
            ST_INIT: begin
                rf_we_next   = 1'b1;
                rf_addr_next = cnt_reg;
                rf_d_next    = '0;
                if (cnt_reg == AW'(NREG - 1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + AW'(1);
                end
            end
            ST_RUN: begin
                // Writes to x0 consume the grant but never reach the register file.
                if (accept && (sel_addr != '0)) begin
                    rf_we_next   = 1'b1;
                    rf_addr_next = sel_addr;
                    rf_d_next    = sel_data;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= ST_INIT;
            cnt_reg     <= '0;
            rf_we_reg   <= 1'b0;
            rf_addr_reg <= '0;
            rf_d_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rf_we_reg   <= rf_we_next;
            rf_addr_reg <= rf_addr_next;
            rf_d_reg    <= rf_d_next;
        end
    end

    assign rf_we   = rf_we_reg;
    assign rf_addr = rf_addr_reg;
    assign rf_d    = rf_d_reg;
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Directed bench for regfile_wr_sched with a behavioural register file fed by the rf ports.
module tb_regfile_wr_sched;
    import rv32i_pkg::*;

    logic            clk = 1'b0;
    logic            clr;
    logic            req0_valid, req1_valid;
    logic [AW-1:0]   req0_addr, req1_addr;
    logic [XLEN-1:0] req0_data, req1_data;
    logic            req0_ready, req1_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_addr;
    logic [XLEN-1:0] rf_d;
    logic            init_busy;

    logic [XLEN-1:0] rf_model [NREG];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wr_sched dut (
        .clk        (clk),
        .clr        (clr),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_d       (rf_d),
        .init_busy  (init_busy)
    );

    // Register file: poisoned on clr so a missing zero-fill is visible.
    always @(posedge clk) begin
        if (clr) begin
            for (int j = 0; j < NREG; j++) rf_model[j] <= 32'hA5A5_A5A5;
        end else if (rf_we) begin
            rf_model[rf_addr] <= rf_d;
            $display("[%0t] rf write x%0d <= %h", $time, rf_addr, rf_d);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_walk(input string tag);
        for (int i = 0; i < NREG; i++) begin
            tick();
            check({tag, "_we"},   32'(rf_we),   32'd1);
            check({tag, "_addr"}, 32'(rf_addr), 32'(i));
            check({tag, "_d"},    rf_d,         32'd0);
            check({tag, "_busy"}, 32'(init_busy), (i < NREG - 1) ? 32'd1 : 32'd0);
            check({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
            check({tag, "_rdy1"}, 32'(req1_ready), 32'd0);
            if (i == NREG - 2) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
    endtask

    function automatic int count_nonzero();
        int n = 0;
        for (int j = 0; j < NREG; j++) if (rf_model[j] !== 32'd0) n++;
        return n;
    endfunction

    initial begin
        clr = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        tick();
        check("rst_we",   32'(rf_we),      32'd0);
        check("rst_addr", 32'(rf_addr),    32'd0);
        check("rst_d",    rf_d,            32'd0);
        check("rst_busy", 32'(init_busy),  32'd1);
        check("rst_rdy0", 32'(req0_ready), 32'd0);
        check("rst_rdy1", 32'(req1_ready), 32'd0);

        // Zero-fill with both requesters pushing; they must be ignored.
        clr = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd9;  req0_data = 32'h0000_0909;
        req1_valid = 1'b1; req1_addr = 5'd10; req1_data = 32'h0000_1010;
        init_walk("init");
        tick();
        check("post_init_we", 32'(rf_we), 32'd0);
        check("init_zero_regs", 32'(count_nonzero()), 32'd0);

        // Single write to x5.
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
        #1;
        check("single_rdy0", 32'(req0_ready), 32'd1);
        check("single_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check("single_we",   32'(rf_we),   32'd1);
        check("single_addr", 32'(rf_addr), 32'd5);
        check("single_d",    rf_d,         32'hDEAD_BEEF);
        tick();
        check("single_x5",    rf_model[5], 32'hDEAD_BEEF);
        check("single_we_off", 32'(rf_we), 32'd0);

        // x0 write is accepted but dropped.
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
        #1;
        check("x0_rdy1", 32'(req1_ready), 32'd1);
        check("x0_rdy0", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        check("x0_we", 32'(rf_we), 32'd0);
        tick();
        check("x0_reg", rf_model[0], 32'd0);

        // Contention on x3: req0 first (x0 grant went to req1), then req1.
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h22;
        #1;
        check("cont_rdy0", 32'(req0_ready), 32'd1);
        check("cont_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("cont2_rdy1", 32'(req1_ready), 32'd1);
        check("cont_we1",   32'(rf_we),      32'd1);
        check("cont_d1",    rf_d,            32'h11);
        tick();
        req1_valid = 1'b0;
        check("cont_addr2", 32'(rf_addr), 32'd3);
        check("cont_d2",    rf_d,         32'h22);
        tick();
        check("cont_x3", rf_model[3], 32'h22);

        // Sustained dual requests alternate 0,1,0,1...
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hA0A0;
        req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hB1B1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("alt_rdy0", 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            check("alt_rdy1", 32'(req1_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            check("alt_d", rf_d, (i % 2 == 0) ? 32'hA0A0 : 32'hB1B1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Idle: port holds, nothing written.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_we",   32'(rf_we),   32'd0);
            check("idle_addr", 32'(rf_addr), 32'd11);
            check("idle_d",    rf_d,         32'hB1B1);
        end
        check("idle_x10", rf_model[10], 32'hA0A0);

        // Arbitration order survived idle; reset while req0 is being accepted.
        req0_valid = 1'b1; req0_addr = 5'd7;  req0_data = 32'h1234;
        req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 32'h5678;
        #1;
        check("post_idle_rdy0", 32'(req0_ready), 32'd1);
        check("post_idle_rdy1", 32'(req1_ready), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("mid_rst_we",   32'(rf_we),     32'd0);
        check("mid_rst_addr", 32'(rf_addr),   32'd0);
        check("mid_rst_busy", 32'(init_busy), 32'd1);
        init_walk("reinit");
        tick();
        check("reinit_x7", rf_model[7], 32'd0);
        check("reinit_zero_regs", 32'(count_nonzero()), 32'd0);

        // After reset requester 0 again wins the first tie.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("reinit_rdy0", 32'(req0_ready), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
